// File: rtl/io_board_responder.sv
// Board-side responder for the I/O expansion bus: synchronizes the bus, filters board inputs,
// services writes/reads for BOARD_ADDR. Optional output watchdog via IO_BOARD_WATCHDOG_EN.
module io_board_responder #(
  parameter logic [3:0]  BOARD_ADDR    = 4'd0,
  parameter logic [7:0]  FILTER_CYCLES = 8'd16,
  parameter logic [23:0] WDT_CYCLES    = 24'd1000000,
  parameter logic [7:0]  OUT_SAFE      = 8'h00
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] io_address,
  input  logic [1:0] io_enable_n,
  inout  wire  [7:0] io_data,
  input  logic [7:0] board_inputs,
  output logic [7:0] board_outputs,
  output logic       access_wr,
  output logic       access_rd,
  output logic       bus_error
);

  if (FILTER_CYCLES == 8'd0 || WDT_CYCLES == 24'd0) begin : g_param_check
    $error("io_board_responder: FILTER_CYCLES and WDT_CYCLES must be non-zero");
  end

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RELEASE, ERROR} state_t;

  state_t     state, next_state;
  logic [3:0] addr_s1, addr_s2;
  logic [1:0] en_s1, en_s2;
  logic [7:0] data_s1, data_s2;
  logic [7:0] in_s1, in_s2;
  logic [7:0] filt;
  logic [7:0] fcnt [8];
  logic [7:0] snap_reg;
  logic       oe;
  logic       s_wr, s_rd, match;
  logic       wr_accept, rd_accept, oe_next, err_set;

  // Strobe synchronizers reset to the released level so reset does not look like a strobe.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr_s1 <= '0;
      addr_s2 <= '0;
      en_s1   <= '1;
      en_s2   <= '1;
      data_s1 <= '0;
      data_s2 <= '0;
      in_s1   <= '0;
      in_s2   <= '0;
    end else begin
      addr_s1 <= io_address;
      addr_s2 <= addr_s1;
      en_s1   <= io_enable_n;
      en_s2   <= en_s1;
      data_s1 <= io_data;
      data_s2 <= data_s1;
      in_s1   <= board_inputs;
      in_s2   <= in_s1;
    end
  end

  assign s_wr  = ~en_s2[0];
  assign s_rd  = ~en_s2[1];
  assign match = (addr_s2 == BOARD_ADDR);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      filt <= '0;
      for (int unsigned i = 0; i < 8; i++) fcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (in_s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILTER_CYCLES - 8'd1) begin
          filt[i] <= in_s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 8'd1;
        end
      end
    end
  end

  // Write data and the read snapshot are captured on the IDLE exit edge so both
  // take effect three cycles after the raw strobe edge.
  always_comb begin
    next_state = state;
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    oe_next    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (s_wr && s_rd) begin
          next_state = ERROR;
          err_set    = 1'b1;
        end else if (s_wr && match) begin
          next_state = WRITE;
          wr_accept  = 1'b1;
        end else if (s_rd && match) begin
          next_state = READ;
          rd_accept  = 1'b1;
          oe_next    = 1'b1;
        end
      end
      WRITE: next_state = WAIT_RELEASE;
      READ: begin
        if (s_wr) begin
          next_state = ERROR;
          err_set    = 1'b1;
        end else if (!s_rd) begin
          next_state = IDLE;
        end else begin
          oe_next = 1'b1;
        end
      end
      WAIT_RELEASE, ERROR: begin
        if (!s_wr && !s_rd) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      oe        <= 1'b0;
      access_wr <= 1'b0;
      access_rd <= 1'b0;
      bus_error <= 1'b0;
      snap_reg  <= '0;
    end else begin
      state     <= next_state;
      oe        <= oe_next;
      access_wr <= wr_accept;
      access_rd <= rd_accept;
      if (err_set) bus_error <= 1'b1;
      if (rd_accept) snap_reg <= filt;
    end
  end

  assign io_data = oe ? snap_reg : 8'bzzzz_zzzz;

`ifdef IO_BOARD_WATCHDOG_EN
  logic [23:0] wdt_cnt;
  logic        wdt_fire;

  // Fires only on the step into WDT_CYCLES; the counter then saturates.
  assign wdt_fire = (wdt_cnt == WDT_CYCLES - 24'd1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wdt_cnt <= '0;
    end else if (wr_accept) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_CYCLES) begin
      wdt_cnt <= wdt_cnt + 24'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      board_outputs <= OUT_SAFE;
    end else if (wr_accept) begin
      board_outputs <= data_s2;
    end else if (wdt_fire) begin
      board_outputs <= OUT_SAFE;
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (Rst) begin
      board_outputs <= OUT_SAFE;
    end else if (wr_accept) begin
      board_outputs <= data_s2;
    end
  end
`endif

endmodule
